// File: rtl/wordle_guess_engine.sv
// Wordle guess engine: collects letter entry into a 5-cell row and scores it against
// the latched target with duplicate-aware rules, driving the renderer's cell bus.
module wordle_guess_engine #(
  parameter int         MAX_GUESSES = 6,
  parameter logic [4:0] BLANK_CODE  = 5'd26
) (
  input  logic        dclk,
  input  logic        clr,
  input  logic        new_game,
  input  logic [24:0] target_word,
  input  logic        letter_valid,
  input  logic [4:0]  letter_code,
  input  logic        backspace,
  input  logic        submit,
  output logic [34:0] display,
  output logic        busy,
  output logic        eval_done,
  output logic [2:0]  guess_count,
  output logic        win,
  output logic        lose
);

  // state    | meaning
  // ENTRY    | typing letters into the current row
  // GREEN    | exact-position matches computed
  // YELLOW   | one guess position per cycle checked for misplaced letters
  // RESULT   | scored row shown, waiting for the first letter of the next guess
  // WON      | game won, display frozen
  // LOST     | game lost, target revealed
  localparam logic [2:0] S_ENTRY  = 3'd0;
  localparam logic [2:0] S_GREEN  = 3'd1;
  localparam logic [2:0] S_YELLOW = 3'd2;
  localparam logic [2:0] S_RESULT = 3'd3;
  localparam logic [2:0] S_WON    = 3'd4;
  localparam logic [2:0] S_LOST   = 3'd5;

  localparam logic [6:0]  CELL_BLANK = {2'b00, BLANK_CODE};
  localparam logic [34:0] ROW_BLANK  = {5{CELL_BLANK}};
  localparam logic [2:0]  MAX_GC     = 3'(MAX_GUESSES);

  logic [2:0]  state_q, state_d;
  logic [34:0] display_q, display_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  gcnt_q, gcnt_d;
  logic        win_q, win_d;
  logic        lose_q, lose_d;
  logic        eval_done_q, eval_done_d;
  logic [24:0] target_q, target_d;
  logic [4:0]  g_q, g_d;
  logic [4:0]  y_q, y_d;
  logic [4:0]  used_q, used_d;
  logic [2:0]  idx_q, idx_d;

  logic        letter_ok;
  logic [4:0]  cur_letter;
  logic        yel_hit;
  logic [2:0]  yel_j;
  logic [2:0]  gcnt_next;

  assign letter_ok = letter_valid && (letter_code <= 5'd25);
  assign gcnt_next = (gcnt_q < MAX_GC) ? gcnt_q + 3'd1 : gcnt_q;

  // Lowest unused target position matching the guess letter under examination.
  always_comb begin
    cur_letter = '0;
    yel_hit    = 1'b0;
    yel_j      = '0;
    for (int i = 0; i < 5; i++)
      if (idx_q == 3'(i)) cur_letter = display_q[7*i +: 5];
    for (int j = 4; j >= 0; j--) begin
      if (!used_q[j] && (target_q[5*j +: 5] == cur_letter)) begin
        yel_hit = 1'b1;
        yel_j   = 3'(j);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    display_d   = display_q;
    len_d       = len_q;
    gcnt_d      = gcnt_q;
    win_d       = win_q;
    lose_d      = lose_q;
    eval_done_d = 1'b0;
    target_d    = target_q;
    g_d         = g_q;
    y_d         = y_q;
    used_d      = used_q;
    idx_d       = idx_q;

    if (new_game) begin
      state_d   = S_ENTRY;
      display_d = ROW_BLANK;
      len_d     = '0;
      gcnt_d    = '0;
      win_d     = 1'b0;
      lose_d    = 1'b0;
      target_d  = target_word;
      g_d       = '0;
      y_d       = '0;
      used_d    = '0;
      idx_d     = '0;
    end else begin
      case (state_q)
        S_ENTRY: begin
          if (submit) begin
            if (len_q == 3'd5) state_d = S_GREEN;
          end else if (backspace) begin
            if (len_q != 3'd0) begin
              len_d = len_q - 3'd1;
              for (int i = 0; i < 5; i++)
                if (len_q == 3'(i + 1)) display_d[7*i +: 7] = CELL_BLANK;
            end
          end else if (letter_ok && (len_q < 3'd5)) begin
            len_d = len_q + 3'd1;
            for (int i = 0; i < 5; i++)
              if (len_q == 3'(i)) display_d[7*i +: 7] = {2'b00, letter_code};
          end
        end
        S_GREEN: begin
          for (int i = 0; i < 5; i++)
            g_d[i] = (display_q[7*i +: 5] == target_q[5*i +: 5]);
          used_d  = g_d;
          y_d     = '0;
          idx_d   = '0;
          state_d = S_YELLOW;
        end
        S_YELLOW: begin
          if (!g_q[idx_q] && yel_hit) begin
            y_d[idx_q]    = 1'b1;
            used_d[yel_j] = 1'b1;
          end
          if (idx_q == 3'd4) begin
            // All five statuses land on one edge so the renderer never sees a partial row.
            for (int i = 0; i < 5; i++)
              display_d[7*i + 5 +: 2] = g_q[i] ? 2'd1 : (y_d[i] ? 2'd2 : 2'd0);
            gcnt_d      = gcnt_next;
            eval_done_d = 1'b1;
            if (&g_q) begin
              state_d = S_WON;
              win_d   = 1'b1;
            end else if (gcnt_next == MAX_GC) begin
              state_d = S_LOST;
              lose_d  = 1'b1;
              for (int i = 0; i < 5; i++)
                display_d[7*i +: 7] = {2'b11, target_q[5*i +: 5]};
            end else begin
              state_d = S_RESULT;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        S_RESULT: begin
          if (!submit && !backspace && letter_ok) begin
            display_d        = ROW_BLANK;
            display_d[6:0]   = {2'b00, letter_code};
            len_d            = 3'd1;
            state_d          = S_ENTRY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state_q     <= S_ENTRY;
      display_q   <= ROW_BLANK;
      len_q       <= '0;
      gcnt_q      <= '0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      eval_done_q <= 1'b0;
      target_q    <= '0;
      g_q         <= '0;
      y_q         <= '0;
      used_q      <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      display_q   <= display_d;
      len_q       <= len_d;
      gcnt_q      <= gcnt_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
      eval_done_q <= eval_done_d;
      target_q    <= target_d;
      g_q         <= g_d;
      y_q         <= y_d;
      used_q      <= used_d;
      idx_q       <= idx_d;
    end
  end

  assign display     = display_q;
  assign busy        = (state_q == S_GREEN) || (state_q == S_YELLOW);
  assign eval_done   = eval_done_q;
  assign guess_count = gcnt_q;
  assign win         = win_q;
  assign lose        = lose_q;

endmodule

// File: tb/tb_wordle_guess_engine.sv
// Directed bench for wordle_guess_engine: entry edits, duplicate-aware scoring,
// win/lose routing, abort via new_game and asynchronous clear mid-scoring.
module tb_wordle_guess_engine;

  localparam logic [4:0] LA = 5'd0,  LB = 5'd1,  LC = 5'd2,  LE = 5'd4;
  localparam logic [4:0] LL = 5'd11, LM = 5'd12, LN = 5'd13, LR = 5'd17;
  localparam logic [4:0] LT = 5'd19, LX = 5'd23, LY = 5'd24, BL = 5'd26;
  localparam logic [34:0] ROW_BLANK = {5{7'h1A}};

  logic        dclk = 1'b0;
  logic        clr, new_game, letter_valid, backspace, submit;
  logic [24:0] target_word;
  logic [4:0]  letter_code;
  logic [34:0] display;
  logic        busy, eval_done, win, lose;
  logic [2:0]  guess_count;

  int total = 0;
  int bad   = 0;

  wordle_guess_engine dut (
    .dclk(dclk), .clr(clr), .new_game(new_game), .target_word(target_word),
    .letter_valid(letter_valid), .letter_code(letter_code), .backspace(backspace),
    .submit(submit), .display(display), .busy(busy), .eval_done(eval_done),
    .guess_count(guess_count), .win(win), .lose(lose)
  );

  always #20 dclk = ~dclk;

  function automatic logic [24:0] w5(input logic [4:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  function automatic logic [9:0] s5(input logic [1:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  function automatic logic [34:0] mk(input logic [24:0] w, input logic [9:0] st);
    logic [34:0] r;
    for (int i = 0; i < 5; i++) r[7*i +: 7] = {st[2*i +: 2], w[5*i +: 5]};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge dclk);
  endtask

  task automatic pulse_letter(input logic [4:0] c);
    letter_valid = 1'b1;
    letter_code  = c;
    @(negedge dclk);
    letter_valid = 1'b0;
  endtask

  task automatic type_word(input logic [24:0] w);
    for (int i = 0; i < 5; i++) pulse_letter(w[5*i +: 5]);
  endtask

  task automatic do_bs();
    backspace = 1'b1;
    @(negedge dclk);
    backspace = 1'b0;
  endtask

  task automatic do_submit();
    submit = 1'b1;
    @(negedge dclk);
    submit = 1'b0;
  endtask

  task automatic do_new(input logic [24:0] w);
    new_game    = 1'b1;
    target_word = w;
    @(negedge dclk);
    new_game    = 1'b0;
  endtask

  // Entered in cycle T+1 of a scoring run; leaves in T+8.
  task automatic finish_score(input string tag, input logic [34:0] exp, input logic [2:0] gc);
    chk({tag, "_busy_t1"}, 64'(busy), 64'd1);
    wait_cyc(5);
    chk({tag, "_busy_t6"}, 64'(busy), 64'd1);
    chk({tag, "_done_t6"}, 64'(eval_done), 64'd0);
    wait_cyc(1);
    chk({tag, "_disp"}, 64'(display), 64'(exp));
    chk({tag, "_done_t7"}, 64'(eval_done), 64'd1);
    chk({tag, "_gc"}, 64'(guess_count), 64'(gc));
    chk({tag, "_busy_t7"}, 64'(busy), 64'd0);
    wait_cyc(1);
    chk({tag, "_done_t8"}, 64'(eval_done), 64'd0);
  endtask

  task automatic score(input string tag, input logic [34:0] exp, input logic [2:0] gc);
    do_submit();
    finish_score(tag, exp, gc);
  endtask

  logic [24:0] crane, react, aaaaa, llama, alley, bbbbb;
  logic [34:0] frozen;

  initial begin
    crane = w5(LC, LR, LA, LN, LE);
    react = w5(LR, LE, LA, LC, LT);
    aaaaa = w5(LA, LA, LA, LA, LA);
    llama = w5(LL, LL, LA, LM, LA);
    alley = w5(LA, LL, LL, LE, LY);
    bbbbb = w5(LB, LB, LB, LB, LB);

    clr = 1'b1; new_game = 1'b0; target_word = '0; letter_valid = 1'b0;
    letter_code = '0; backspace = 1'b0; submit = 1'b0;
    #5;
    chk("rst_disp", 64'(display), 64'(ROW_BLANK));
    chk("rst_flags", 64'({busy, eval_done, win, lose, guess_count}), 64'd0);
    wait_cyc(2);
    clr = 1'b0;
    wait_cyc(1);

    // Basic scoring against CRANE
    do_new(crane);
    chk("new_disp", 64'(display), 64'(ROW_BLANK));
    type_word(react);
    chk("react_typed", 64'(display), 64'(mk(react, '0)));
    score("react", mk(react, s5(2, 2, 1, 2, 0)), 3'd1);

    // First letter in RESULT clears the row
    pulse_letter(LA);
    chk("result_clear", 64'(display), 64'(mk(w5(LA, BL, BL, BL, BL), '0)));
    for (int i = 0; i < 4; i++) pulse_letter(LA);
    score("aaaaa", mk(aaaaa, s5(0, 0, 1, 0, 0)), 3'd2);

    // Entry edges: overflow, backspace, invalid code, short submit
    type_word(llama);
    pulse_letter(LX);
    chk("entry_full", 64'(display), 64'(mk(llama, '0)));
    do_bs();
    do_bs();
    chk("entry_bs", 64'(display), 64'(mk(w5(LL, LL, LA, BL, BL), '0)));
    pulse_letter(5'd27);
    chk("entry_badcode", 64'(display), 64'(mk(w5(LL, LL, LA, BL, BL), '0)));
    do_submit();
    chk("short_submit_busy", 64'(busy), 64'd0);
    chk("short_submit_disp", 64'(display), 64'(mk(w5(LL, LL, LA, BL, BL), '0)));

    // Simultaneous submit+backspace+letter with len=5
    pulse_letter(LM);
    pulse_letter(LA);
    submit = 1'b1; backspace = 1'b1; letter_valid = 1'b1; letter_code = 5'd5;
    @(negedge dclk);
    submit = 1'b0; backspace = 1'b0; letter_valid = 1'b0;
    chk("simul_letters", 64'(display), 64'(mk(llama, '0)));
    finish_score("simul", mk(llama, s5(0, 0, 1, 0, 0)), 3'd3);

    // Duplicates with target LLAMA, then win
    do_new(llama);
    chk("new2_gc", 64'(guess_count), 64'd0);
    type_word(alley);
    score("alley", mk(alley, s5(2, 1, 2, 0, 0)), 3'd1);
    type_word(llama);
    score("win", mk(llama, s5(1, 1, 1, 1, 1)), 3'd2);
    chk("win_flag", 64'({win, lose}), 64'b10);
    pulse_letter(LB);
    do_bs();
    do_submit();
    wait_cyc(8);
    chk("win_frozen", 64'(display), 64'(mk(llama, s5(1, 1, 1, 1, 1))));
    chk("win_gc_frozen", 64'(guess_count), 64'd2);
    chk("win_sticky", 64'({win, busy}), 64'b10);

    // Abort scoring with new_game at T+3
    do_new(crane);
    chk("new3_win_clr", 64'({win, lose, guess_count}), 64'd0);
    type_word(react);
    do_submit();
    wait_cyc(2);
    new_game = 1'b1;
    target_word = llama;
    @(negedge dclk);
    new_game = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_disp", 64'(display), 64'(ROW_BLANK));
    chk("abort_gc", 64'(guess_count), 64'd0);
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_done", 64'(eval_done), 64'd0);
      wait_cyc(1);
    end
    type_word(llama);
    score("abort_target", mk(llama, s5(1, 1, 1, 1, 1)), 3'd1);

    // Lose after MAX_GUESSES wrong guesses
    do_new(crane);
    for (int g = 1; g <= 5; g++) begin
      type_word(bbbbb);
      score("wrong", mk(bbbbb, '0), 3'(g));
      chk("wrong_nolose", 64'(lose), 64'd0);
    end
    type_word(bbbbb);
    score("lose", mk(crane, s5(3, 3, 3, 3, 3)), 3'd6);
    chk("lose_flag", 64'({win, lose}), 64'b01);
    frozen = display;
    pulse_letter(LA);
    do_submit();
    wait_cyc(8);
    chk("lose_frozen", 64'(display), 64'(mk(crane, s5(3, 3, 3, 3, 3))));
    chk("lose_gc_sat", 64'(guess_count), 64'd6);

    // Asynchronous clear in the middle of YELLOW
    do_new(crane);
    type_word(react);
    score("pre_clr", mk(react, s5(2, 2, 1, 2, 0)), 3'd1);
    type_word(alley);
    do_submit();
    wait_cyc(2);
    #7;
    clr = 1'b1;
    #3;
    chk("clr_disp", 64'(display), 64'(ROW_BLANK));
    chk("clr_flags", 64'({busy, eval_done, win, lose, guess_count}), 64'd0);
    @(negedge dclk);
    clr = 1'b0;
    wait_cyc(8);
    chk("clr_no_done", 64'({eval_done, busy}), 64'd0);
    chk("clr_disp_hold", 64'(display), 64'(ROW_BLANK));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
